// File: rtl/reg_file_wb.sv
// Write-back register file: 2^A x D registers, two forwarded combinational read ports,
// and a one-entry write-back latch that commits to the array on the following edge.
module reg_file_wb #(
  parameter int D = 8,
  parameter int A = 3
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         WrEn,
  input  logic         WrSrc,
  input  logic [D-1:0] ImmIn,
  input  logic [D-1:0] AluIn,
  input  logic [A-1:0] WrAddr,
  input  logic         Stall,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  output logic [D-1:0] DataOutA,
  output logic [D-1:0] DataOutB,
  output logic         WbBusy
);

  localparam int NREG = 2 ** A;

  logic [D-1:0] regs [NREG];
  logic         wb_valid;
  logic [A-1:0] wb_addr;
  logic [D-1:0] wb_data;
  logic         capture;

  assign capture = WrEn && !Stall;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= capture;
      if (capture) begin
        wb_addr <= WrAddr;
        wb_data <= WrSrc ? ImmIn : AluIn;
      end
    end
  end

  // Commit ignores Stall: anything in the latch lands exactly one edge after capture.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_valid) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign DataOutA = (wb_valid && (wb_addr == RaddrA)) ? wb_data : regs[RaddrA];
  assign DataOutB = (wb_valid && (wb_addr == RaddrB)) ? wb_data : regs[RaddrB];
  assign WbBusy   = wb_valid;

endmodule
